// File: rtl/rle_sched_pkg.sv
// rle_sched_pkg: scheduler state encoding, header tag and header builder
// shared by rle_frame_sched and its bench.
package rle_sched_pkg;
   typedef enum logic [1:0] {IDLE, HDR, STREAM, DRAIN} state_t;
   localparam logic [3:0] HDR_TAG = 4'hF;
   function automatic logic [63:0] build_hdr(input int unsigned width, input logic [15:0] ch);
      build_hdr = ({60'd0, HDR_TAG} << (width - 4)) | {48'd0, ch};
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first requester at or after ptr (cyclic).
module rr_pick #(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] ptr,
   output logic                    valid,
   output logic [$clog2(N_CH)-1:0] idx
);
   localparam int IW = $clog2(N_CH);
   always_comb begin
      int c;
      c = 0;
      valid = 1'b0;
      idx = ptr;
      // scan downwards so the nearest requester after ptr writes last
      for (int k = N_CH - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % N_CH;
         if (req[c]) begin
            valid = 1'b1;
            idx = IW'(c);
         end
      end
   end
endmodule

// File: rtl/rle_frame_sched.sv
// rle_frame_sched: grants one shared RLE kernel to one channel per frame, drains it, re-arbitrates.
// Define RLE_FRAME_HDR_EN to emit a {F, zeros, ch} header word ahead of each frame.
module rle_frame_sched
   import rle_sched_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int WIDTH        = 16,
   parameter int PIXEL_COUNT  = 1600,
   parameter int QUIET_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH*WIDTH-1:0]   ch_data,
   input  logic [N_CH-1:0]         ch_avail,
   output logic [N_CH-1:0]         ch_read,
   output logic [WIDTH-1:0]        k_input,
   output logic                    k_avail,
   input  logic                    k_read,
   input  logic [WIDTH-1:0]        k_output,
   input  logic                    k_write,
   output logic                    k_afull,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_write,
   input  logic                    out_afull,
   output logic                    busy,
   output logic [$clog2(N_CH)-1:0] cur_ch,
   output logic                    frame_done
);
   localparam int IW = $clog2(N_CH);
   localparam int PW = $clog2(PIXEL_COUNT + 1);
   localparam int QW = $clog2(QUIET_CYCLES + 1);
`ifdef RLE_FRAME_HDR_EN
   localparam state_t FIRST = HDR;
`else
   localparam state_t FIRST = STREAM;
`endif

   state_t        state;
   logic [IW-1:0] grant, rr_ptr, pick_idx;
   logic          pick_valid, streaming, draining, pix_last, quiet_done;
   logic [PW-1:0] pix_cnt;
   logic [QW-1:0] quiet_cnt;

   rr_pick #(.N_CH(N_CH)) u_pick (
      .req  (ch_avail),
      .ptr  (rr_ptr),
      .valid(pick_valid),
      .idx  (pick_idx)
   );

   assign streaming  = state == STREAM;
   assign draining   = state == DRAIN;
   assign busy       = state != IDLE;
   assign cur_ch     = grant;
   assign k_input    = ch_data[int'(grant)*WIDTH +: WIDTH];
   assign k_avail    = streaming & ch_avail[grant];
   // holding afull outside the grant window keeps stray kernel words off the output
   assign k_afull    = out_afull | (state == IDLE) | (state == HDR);
   assign pix_last   = pix_cnt == PW'(PIXEL_COUNT - 1);
   assign quiet_done = draining & ~k_write & ~out_afull & (quiet_cnt == QW'(QUIET_CYCLES - 1));

   always_comb begin
      ch_read = '0;
      ch_read[grant] = streaming & k_read;
   end

`ifdef RLE_FRAME_HDR_EN
   logic [WIDTH-1:0] hdr;
   assign hdr       = WIDTH'(build_hdr(WIDTH, 16'(grant)));
   assign out_data  = state == HDR ? hdr : k_output;
   assign out_write = ((state == HDR) & ~out_afull) | (k_write & (streaming | draining));
`else
   assign out_data  = k_output;
   assign out_write = k_write & (streaming | draining);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= '0;
         pix_cnt    <= '0;
         quiet_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= quiet_done;
         case (state)
            IDLE: if (pick_valid) begin
               grant <= pick_idx;
               state <= FIRST;
            end
            HDR: if (!out_afull) state <= STREAM;
            STREAM: if (k_read) begin
               pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
               if (pix_last) state <= DRAIN;
            end
            DRAIN: begin
               quiet_cnt <= (k_write | quiet_done) ? '0 : out_afull ? quiet_cnt : quiet_cnt + 1'b1;
               if (quiet_done) begin
                  rr_ptr <= grant == IW'(N_CH - 1) ? '0 : grant + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rle_frame_sched.sv
// tb_rle_frame_sched: directed bench with FIFO/echo-kernel stand-ins and a frame-level scoreboard.
// Honours RLE_FRAME_HDR_EN the same way the design does.
module tb_rle_frame_sched;
   localparam int N = 4, W = 16, PC = 4, Q = 8;
`ifdef RLE_FRAME_HDR_EN
   localparam bit HDR_ON = 1'b1;
`else
   localparam bit HDR_ON = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b0;
   logic [N*W-1:0] ch_data = '0;
   logic [N-1:0] ch_avail = '0, ch_read;
   logic [W-1:0] k_input, k_output = '0, out_data;
   logic k_avail, k_read, k_write, k_afull, out_write, busy, frame_done;
   logic out_afull = 1'b0, kr_en = 1'b1, kq_nz = 1'b0;
   logic [1:0] cur_ch;
   logic [N-1:0] hold = '0;

   logic [W-1:0] fifo[N][$];
   logic [W-1:0] kq[$];
   logic [W-1:0] exp_out[$];
   logic [W-1:0] out_log[$];
   int glog[$];
   int errors = 0, checks = 0, cyc = 0, rd_cnt = 0, done_cnt = 0, first_rd = -1;
   int m_ptr = 0, exp_ch = 0;
   logic prev_busy = 1'b0;
   logic [N-1:0] avail_prev = '0, pend_rd = '0;
   logic pend_kr = 1'b0, pend_kw = 1'b0;
   logic [W-1:0] kin = '0;

   assign k_read  = k_avail & kr_en;
   assign k_write = kq_nz & ~k_afull;

   always #5 clk = ~clk;

   rle_frame_sched #(.N_CH(N), .WIDTH(W), .PIXEL_COUNT(PC), .QUIET_CYCLES(Q)) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data), .ch_avail(ch_avail), .ch_read(ch_read),
      .k_input(k_input), .k_avail(k_avail), .k_read(k_read), .k_output(k_output),
      .k_write(k_write), .k_afull(k_afull), .out_data(out_data), .out_write(out_write),
      .out_afull(out_afull), .busy(busy), .cur_ch(cur_ch), .frame_done(frame_done)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] av, input int p);
      for (int k = 0; k < N; k++) if (av[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         ch_avail[i] = fifo[i].size() != 0 && !hold[i];
         ch_data[i*W +: W] = fifo[i].size() != 0 ? fifo[i][0] : '0;
      end
      kq_nz = kq.size() != 0;
      k_output = kq_nz ? kq[0] : '0;
   endtask

   // One clock: sample and score at negedge, commit handshakes just after posedge.
   task automatic step();
      drive();
      @(negedge clk);
      cyc++;
      if (rst) begin
         kq.delete(); exp_out.delete();
         m_ptr = 0; rd_cnt = 0; prev_busy = 1'b0;
         pend_rd = '0; pend_kr = 1'b0; pend_kw = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            exp_ch = pick(avail_prev, m_ptr);
            glog.push_back(exp_ch);
            rd_cnt = 0;
            if (HDR_ON) exp_out.push_back(16'hF000 | 16'(exp_ch));
         end
         if (busy) chk("cur_ch", cur_ch, exp_ch);
         else chk("idle_rd", ch_read, 0);
         for (int i = 0; i < N; i++) if (ch_read[i]) begin
            chk("rd_ch", i, exp_ch);
            chk("rd_avail", ch_avail[i], 1);
            rd_cnt++;
            chk("rd_over", rd_cnt <= PC, 1);
            if (first_rd < 0) first_rd = cyc;
            exp_out.push_back(fifo[i][0]);
         end
         if (out_write) begin
            chk("wr_afull", out_afull, 0);
            chk("wr_pending", exp_out.size() > 0, 1);
            if (exp_out.size() > 0) chk("out_data", out_data, exp_out.pop_front());
            out_log.push_back(out_data);
         end
         if (frame_done) begin
            chk("fd_reads", rd_cnt, PC);
            chk("fd_drained", exp_out.size(), 0);
            chk("fd_idle", busy, 0);
            m_ptr = (exp_ch + 1) % N;
            done_cnt++;
         end
         pend_rd = ch_read; pend_kr = k_read; pend_kw = k_write; kin = k_input;
         prev_busy = busy; avail_prev = ch_avail;
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int i = 0; i < N; i++) if (pend_rd[i]) void'(fifo[i].pop_front());
         if (pend_kw) void'(kq.pop_front());
         if (pend_kr) kq.push_back(kin);
      end
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 400) begin step(); t++; end
      chk("wait_done", done_cnt, n);
   endtask

   task automatic wait_rd(input int g0, input int n);
      int t = 0;
      while (!(glog.size() > g0 && rd_cnt >= n) && t < 200) begin step(); t++; end
      chk("wait_rd", rd_cnt, n);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ch_read"}, ch_read, 0);
      chk({tag, "_k_avail"}, k_avail, 0);
      chk({tag, "_k_afull"}, k_afull, 1);
      chk({tag, "_out_write"}, out_write, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cur_ch"}, cur_ch, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int start, g0, d0;
      #1 rst = 1'b1;
      #1 chk_reset_outs("rst0");
      step(); step();
      rst = 1'b0;

      // channel 2 alone: 5,5,0,0
      out_log.delete();
      fifo[2] = '{16'd5, 16'd5, 16'd0, 16'd0};
      start = cyc; first_rd = -1;
      wait_done(1);
      chk("t1_grant", glog[0], 2);
      chk("t1_latency", first_rd - start, HDR_ON ? 3 : 2);
      chk("t1_first_word", out_log[0], HDR_ON ? 16'hF002 : 16'd5);
      chk("t1_words", out_log.size(), HDR_ON ? 5 : 4);

      // rr_ptr is now 3: channels 0 and 3 both ready, 3 must go first
      g0 = glog.size();
      fifo[0] = '{16'h11, 16'h12, 16'h13, 16'h14};
      fifo[3] = '{16'h31, 16'h32, 16'h33, 16'h34};
      wait_done(3);
      chk("t2_grant_a", glog[g0], 3);
      chk("t2_grant_b", glog[g0+1], 0);

      // reset while idle, then all four channels busy: 0,1,2,3,0
      rst = 1'b1; step(); rst = 1'b0;
      g0 = glog.size(); d0 = done_cnt;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < (i == 0 ? 2 * PC : PC); j++) fifo[i].push_back(16'(16'h100 * i + j));
      wait_done(d0 + 5);
      for (int i = 0; i < 5; i++) chk("t3_grant", glog[g0+i], i % N);

      // downstream afull during header/early phase and during drain
      d0 = done_cnt; g0 = glog.size();
      out_afull = 1'b1;
      fifo[1] = '{16'hA1, 16'hA2, 16'hA3, 16'hA4};
      repeat (20) step();
      chk("t4_no_done_a", done_cnt, d0);
      out_afull = 1'b0;
      wait_rd(g0, PC);
      out_afull = 1'b1;
      repeat (20) step();
      chk("t4_no_done_b", done_cnt, d0);
      out_afull = 1'b0;
      wait_done(d0 + 1);
      chk("t4_grant", glog[g0], 1);

      // channel 1 stalls mid-frame while channel 2 is ready; grant must hold
      d0 = done_cnt; g0 = glog.size();
      fifo[1] = '{16'hB1, 16'hB2, 16'hB3, 16'hB4};
      wait_rd(g0, 2);
      hold[1] = 1'b1;
      fifo[2] = '{16'hC1, 16'hC2, 16'hC3, 16'hC4};
      repeat (30) step();
      chk("t5_held_reads", rd_cnt, 2);
      chk("t5_held_grant", cur_ch, 1);
      chk("t5_no_done", done_cnt, d0);
      hold[1] = 1'b0;
      wait_done(d0 + 2);
      chk("t5_grant_a", glog[g0], 1);
      chk("t5_grant_b", glog[g0+1], 2);

      // reset mid-stream aborts; next frame starts from channel 0 with a fresh header
      g0 = glog.size();
      fifo[1] = '{16'hD1, 16'hD2, 16'hD3, 16'hD4};
      wait_rd(g0, 2);
      rst = 1'b1;
      #1 chk_reset_outs("rst1");
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) fifo[i].delete();
      out_log.delete();
      d0 = done_cnt; g0 = glog.size();
      fifo[0] = '{16'hE1, 16'hE2, 16'hE3, 16'hE4};
      fifo[2] = '{16'hF1, 16'hF2, 16'hF3, 16'hF4};
      wait_done(d0 + 2);
      chk("t6_grant_a", glog[g0], 0);
      chk("t6_grant_b", glog[g0+1], 2);
      chk("t6_first_word", out_log[0], HDR_ON ? 16'hF000 : 16'hE1);

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
